// File: rtl/kcore_dataflow_start_ctrl_if.sv
// Caller/head/start-FIFO/tail handshake bundle for kcore_dataflow_start_ctrl.
// The master modport is the environment side; the slave modport is the controller.
interface kcore_dataflow_start_ctrl_if #(
    parameter int NUM_HEAD = 2
);
    logic                ap_start;
    logic                ap_ready;
    logic                ap_done;
    logic                ap_continue;
    logic                ap_idle;
    logic [NUM_HEAD-1:0] head_start;
    logic [NUM_HEAD-1:0] head_ready;
    logic                sfifo_full_n;
    logic                sfifo_write;
    logic                sfifo_din;
    logic                tail_done;
    logic                tail_continue;

    modport master (
        output ap_start, ap_continue, head_ready, sfifo_full_n, tail_done,
        input  ap_ready, ap_done, ap_idle, head_start, sfifo_write, sfifo_din, tail_continue
    );

    modport slave (
        input  ap_start, ap_continue, head_ready, sfifo_full_n, tail_done,
        output ap_ready, ap_done, ap_idle, head_start, sfifo_write, sfifo_din, tail_continue
    );
endinterface

// File: rtl/kcore_dataflow_start_ctrl.sv
// Start/done sequencer for one kcore dataflow region: fans ap_start to the heads and the start FIFO,
// retires iterations on tail done. Optional perf counters under `KCORE_START_CTRL_PERF_EN.
module kcore_dataflow_start_ctrl #(
    parameter int NUM_HEAD     = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef KCORE_START_CTRL_PERF_EN
    output logic [31:0]                 perf_iter_cnt,
    output logic [31:0]                 perf_stall_cnt,
`endif
    kcore_dataflow_start_ctrl_if.slave  ctl
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [NUM_HEAD-1:0] issued;
    logic                tok_issued;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    done_cnt;

    logic                accept_ok;
    logic [NUM_HEAD-1:0] head_start;
    logic [NUM_HEAD-1:0] head_hs;
    logic                sfifo_write;
    logic                all_go;
    logic                ap_done;
    logic                tail_continue;
    logic                tail_acc;
    logic                retire;

    always_comb begin
        accept_ok     = ctl.ap_start & (inflight < MAX_CNT);
        head_start    = {NUM_HEAD{accept_ok}} & ~issued;
        head_hs       = head_start & ctl.head_ready;
        sfifo_write   = accept_ok & ~tok_issued & ctl.sfifo_full_n;
        // accept_ok gate keeps ap_ready from firing while the in-flight window is full
        all_go        = accept_ok & (&(issued | head_hs)) & (tok_issued | sfifo_write);
        ap_done       = (done_cnt != '0);
        tail_continue = (done_cnt != MAX_CNT);
        // tail_done without tail_continue is dropped so done_cnt never exceeds the window
        tail_acc      = ctl.tail_done & tail_continue;
        retire        = ctl.ap_continue & ap_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued     <= '0;
            tok_issued <= 1'b0;
            inflight   <= '0;
            done_cnt   <= '0;
        end else begin
            if (all_go) begin
                issued     <= '0;
                tok_issued <= 1'b0;
            end else begin
                issued     <= issued | head_hs;
                tok_issued <= tok_issued | sfifo_write;
            end
            inflight <= inflight + CNT_W'(all_go) - CNT_W'(retire);
            done_cnt <= done_cnt + CNT_W'(tail_acc) - CNT_W'(retire);
        end
    end

`ifdef KCORE_START_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_iter_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_iter_cnt  <= perf_iter_cnt + 32'(all_go);
            perf_stall_cnt <= perf_stall_cnt + 32'(ctl.ap_start & ~all_go);
        end
    end
`endif

    assign ctl.head_start    = head_start;
    assign ctl.sfifo_write   = sfifo_write;
    assign ctl.sfifo_din     = 1'b1;
    assign ctl.ap_ready      = all_go;
    assign ctl.ap_done       = ap_done;
    assign ctl.tail_continue = tail_continue;
    assign ctl.ap_idle       = (inflight == '0) & (done_cnt == '0) & ~(|issued) & ~tok_issued;

endmodule

// File: tb/tb_kcore_dataflow_start_ctrl.sv
// Directed bench for kcore_dataflow_start_ctrl with a cycle model and per-cycle output compare.
module tb_kcore_dataflow_start_ctrl;
    localparam int NH  = 2;
    localparam int MAX = 4;

    logic clk;
    logic reset;
    kcore_dataflow_start_ctrl_if #(.NUM_HEAD(NH)) bus ();

`ifdef KCORE_START_CTRL_PERF_EN
    logic [31:0] perf_iter_cnt, perf_stall_cnt;
`endif

    kcore_dataflow_start_ctrl #(.NUM_HEAD(NH), .MAX_INFLIGHT(MAX), .CNT_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef KCORE_START_CTRL_PERF_EN
        .perf_iter_cnt  (perf_iter_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .ctl            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts of accepted/retired iterations plus which start handshakes are still owed.
    int       m_inflight = 0, m_done = 0;
    bit [NH-1:0] m_heads_done = '0;
    bit       m_tok_done = 1'b0;
    int       m_iter = 0, m_stall = 0;
    int       n_inflight, n_done, n_iter, n_stall;
    bit [NH-1:0] n_heads_done;
    bit       n_tok_done;

    always @(negedge clk) begin
        bit          can_take, go, do_retire, every_head;
        bit [NH-1:0] want_head;
        bit          want_tok;
        can_take  = bus.ap_start && (m_inflight < MAX);
        want_head = '0;
        every_head = 1'b1;
        for (int i = 0; i < NH; i++) begin
            want_head[i] = can_take && !m_heads_done[i];
            if (!(m_heads_done[i] || (want_head[i] && bus.head_ready[i]))) every_head = 1'b0;
        end
        want_tok  = can_take && !m_tok_done && bus.sfifo_full_n;
        go        = can_take && every_head && (m_tok_done || want_tok);
        do_retire = bus.ap_continue && (m_done > 0);
        if (!reset) begin
            check("head_start",    bus.head_start,    want_head);
            check("sfifo_write",   bus.sfifo_write,   want_tok);
            check("sfifo_din",     bus.sfifo_din,     1);
            check("ap_ready",      bus.ap_ready,      go);
            check("ap_done",       bus.ap_done,       m_done > 0);
            check("tail_continue", bus.tail_continue, m_done < MAX);
            check("ap_idle",       bus.ap_idle,
                  (m_inflight == 0) && (m_done == 0) && (m_heads_done == 0) && !m_tok_done);
`ifdef KCORE_START_CTRL_PERF_EN
            check("perf_iter_cnt",  perf_iter_cnt,  m_iter);
            check("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
        end
        if (reset) begin
            n_inflight = 0; n_done = 0; n_heads_done = '0; n_tok_done = 0; n_iter = 0; n_stall = 0;
        end else begin
            n_heads_done = go ? '0 : (m_heads_done | (want_head & bus.head_ready));
            n_tok_done   = go ? 1'b0 : (m_tok_done | want_tok);
            n_inflight   = m_inflight + int'(go) - int'(do_retire);
            n_done       = m_done + int'(bus.tail_done && m_done < MAX) - int'(do_retire);
            n_iter       = m_iter + int'(go);
            n_stall      = m_stall + int'(bus.ap_start && !go);
        end
    end

    always @(posedge clk) begin
        m_inflight <= n_inflight; m_done <= n_done; m_heads_done <= n_heads_done;
        m_tok_done <= n_tok_done; m_iter <= n_iter; m_stall <= n_stall;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drain();
        int n_t, n_c;
        bus.ap_start = 1'b0;
        n_t = m_inflight - m_done;
        n_c = m_inflight;
        for (int k = 0; k < n_t; k++) begin bus.tail_done = 1'b1; tick(); end
        bus.tail_done = 1'b0;
        for (int k = 0; k < n_c; k++) begin bus.ap_continue = 1'b1; tick(); end
        bus.ap_continue = 1'b0;
        sample();
        check("drain_idle", bus.ap_idle, 1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] t2_hr [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
        logic [1:0] t2_hs [4] = '{2'b11, 2'b10, 2'b10, 2'b10};
        logic       t2_wr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       t2_rd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1;
        bus.ap_start = 0; bus.ap_continue = 0; bus.head_ready = '0;
        bus.sfifo_full_n = 0; bus.tail_done = 0;
        tick(); tick();
        reset = 1'b0;
        sample();
        check("rst_ap_ready", bus.ap_ready, 0);
        check("rst_ap_done", bus.ap_done, 0);
        check("rst_head_start", bus.head_start, 0);
        check("rst_sfifo_write", bus.sfifo_write, 0);
        check("rst_ap_idle", bus.ap_idle, 1);
        check("rst_tail_continue", bus.tail_continue, 1);
        tick();

        // Same-cycle accept
        bus.ap_start = 1; bus.head_ready = 2'b11; bus.sfifo_full_n = 1;
        sample();
        check("t1_ap_ready", bus.ap_ready, 1);
        check("t1_sfifo_write", bus.sfifo_write, 1);
        tick();
        bus.ap_start = 0;
        sample();
        check("t1_not_idle", bus.ap_idle, 0);
        tick();
        drain();

        // Heads handshake in different cycles
        bus.ap_start = 1;
        for (int c = 0; c < 4; c++) begin
            bus.head_ready = t2_hr[c];
            sample();
            check("t2_head_start", bus.head_start, t2_hs[c]);
            check("t2_sfifo_write", bus.sfifo_write, t2_wr[c]);
            check("t2_ap_ready", bus.ap_ready, t2_rd[c]);
            tick();
        end
        drain();

        // Window fills at four in-flight iterations
        bus.ap_start = 1; bus.head_ready = 2'b11;
        for (int c = 0; c < 6; c++) begin
            sample();
            check("t4_ap_ready", bus.ap_ready, c < 4);
            check("t4_head_start", bus.head_start, (c < 4) ? 2'b11 : 2'b00);
            check("t4_sfifo_write", bus.sfifo_write, c < 4);
            tick();
        end
        bus.tail_done = 1;
        sample(); check("t4_blocked", bus.ap_ready, 0); tick();
        bus.tail_done = 0; bus.ap_continue = 1;
        sample(); check("t4_done", bus.ap_done, 1); check("t4_still_blocked", bus.ap_ready, 0); tick();
        bus.ap_continue = 0;
        sample(); check("t4_fifth_ready", bus.ap_ready, 1); check("t4_fifth_hs", bus.head_start, 2'b11); tick();
        bus.ap_start = 0;

        // Four dones collected, extra done ignored, then four continues
        for (int c = 0; c < 4; c++) begin
            bus.tail_done = 1;
            sample(); check("t5_tail_continue", bus.tail_continue, 1); tick();
        end
        sample();
        check("t5_full_tc", bus.tail_continue, 0);
        check("t5_full_done", bus.ap_done, 1);
        tick();
        bus.tail_done = 0;
        for (int c = 0; c < 4; c++) begin
            bus.ap_continue = 1;
            sample(); check("t5_done_held", bus.ap_done, 1); tick();
        end
        bus.ap_continue = 0;
        sample();
        check("t5_done_fell", bus.ap_done, 0);
        check("t5_idle", bus.ap_idle, 1);
        tick();

        // Accept, tail done and retire in the same cycle
        bus.ap_start = 1;
        sample(); check("t6_acc0", bus.ap_ready, 1); tick();
        sample(); check("t6_acc1", bus.ap_ready, 1); tick();
        bus.ap_start = 0; bus.tail_done = 1;
        tick();
        bus.ap_start = 1; bus.tail_done = 1; bus.ap_continue = 1;
        sample(); check("t6_same_ready", bus.ap_ready, 1); check("t6_same_done", bus.ap_done, 1); tick();
        bus.tail_done = 0; bus.ap_continue = 0;
        sample(); check("t6_done_kept", bus.ap_done, 1); check("t6_acc2", bus.ap_ready, 1); tick();
        sample(); check("t6_acc3", bus.ap_ready, 1); tick();
        sample(); check("t6_window_full", bus.ap_ready, 0); tick();
        drain();

        // Reset with a partially issued iteration
        bus.ap_start = 1; bus.head_ready = 2'b01; bus.sfifo_full_n = 0;
        tick();
        bus.ap_start = 0;
        sample(); check("rm_partial_busy", bus.ap_idle, 0); tick();
        reset = 1; tick(); reset = 0;
        sample(); check("rm_idle", bus.ap_idle, 1); tick();

        // Start FIFO full for five cycles
        reset = 1; tick(); reset = 0;
        bus.ap_start = 1; bus.head_ready = 2'b11; bus.sfifo_full_n = 0;
        for (int c = 0; c < 5; c++) begin
            sample();
            check("t3_stall_ready", bus.ap_ready, 0);
            check("t3_stall_write", bus.sfifo_write, 0);
            tick();
        end
        bus.sfifo_full_n = 1;
        sample();
        check("t3_write", bus.sfifo_write, 1);
        check("t3_ready", bus.ap_ready, 1);
        tick();
        bus.ap_start = 0;
        sample();
`ifdef KCORE_START_CTRL_PERF_EN
        check("t3_perf_stall", perf_stall_cnt, 5);
        check("t3_perf_iter", perf_iter_cnt, 1);
`endif
        check("t3_busy", bus.ap_idle, 0);
        tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/kcore_dataflow_start_ctrl.md
Name: kcore_dataflow_start_ctrl

Overview:
- Start/done sequencer for one kcore dataflow region.
- Fans the region's ap_start out to NUM_HEAD head processes (ap_ctrl_chain style start/ready).
- Pushes one 1-bit start token per iteration into the downstream 1-bit start FIFO (full_n/write side).
- Tracks in-flight iterations, collects the tail process's done, and returns ap_ready/ap_done/ap_idle to the caller under ap_continue back-pressure.

Parameters:
- NUM_HEAD, 2, number of head processes started directly per iteration.
- MAX_INFLIGHT, 4, maximum iterations accepted but not yet retired; equals start FIFO depth.
- CNT_W, 3, counter width; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ap_start  in  1  caller requests an iteration; held until ap_ready.
- ap_ready  out  1  one-cycle pulse: iteration accepted.
- ap_done  out  1  a retired iteration awaits ap_continue.
- ap_continue  in  1  caller consumes one done.
- ap_idle  out  1  no iteration in flight or partially issued.
- head_start  out  NUM_HEAD  per-head start.
- head_ready  in  NUM_HEAD  per-head ready (start consumed).
- sfifo_full_n  in  1  start FIFO not full.
- sfifo_write  out  1  start FIFO write strobe.
- sfifo_din  out  1  start token; constant 1.
- tail_done  in  1  tail process done pulse; one per iteration.
- tail_continue  out  1  continue to tail process.

Behaviour:
- State: issued[NUM_HEAD] sticky bits, tok_issued bit, inflight[CNT_W], done_cnt[CNT_W].
- Reset: all state cleared. With inputs low after reset: ap_ready=0, ap_done=0, head_start=0, sfifo_write=0, ap_idle=1, tail_continue=1.
- accept_ok = ap_start & (inflight < MAX_INFLIGHT).
- head_start[i] = accept_ok & ~issued[i].
  - issued[i] sets when head_start[i] & head_ready[i].
- sfifo_write = accept_ok & ~tok_issued & sfifo_full_n.
  - tok_issued sets when sfifo_write is high.
- all_go = every head either issued or handshaking this cycle, AND the token either issued or written this cycle.
- When all_go is high:
  - ap_ready=1 (combinational, same cycle).
  - All issued bits and tok_issued clear next cycle.
  - inflight increments.
- Heads and the token may complete in any order across cycles. ap_ready fires exactly once per iteration, in the cycle the last handshake completes.
- Iteration-accept latency:
  - Minimum 0 cycles after ap_start sampled: same-cycle ready when all heads are ready and the FIFO is not full.
  - Otherwise, the cycle of the last handshake.
- Completion path:
  - tail_done increments done_cnt.
  - tail_continue = (done_cnt != MAX_INFLIGHT).
  - tail_done arriving while tail_continue is 0 is a protocol error. It is ignored and must not wrap the counter.
- ap_done = (done_cnt != 0).
- On ap_continue & ap_done, next cycle:
  - done_cnt decrements.
  - inflight decrements.
- Simultaneous events in one cycle:
  - tail_done together with ap_continue: done_cnt unchanged.
  - Accept (all_go) together with retire (ap_continue & ap_done): inflight unchanged.
- inflight == MAX_INFLIGHT: head_start=0 and sfifo_write=0 regardless of ap_start. Issued bits already set are held.
- sfifo_full_n low: the token stalls; heads still proceed; ap_ready waits.
- ap_start dropped mid-issue is a protocol violation. Partial issued bits are retained; issue resumes when ap_start returns.
- ap_idle = (inflight==0) & (done_cnt==0) & ~|issued & ~tok_issued.
- Reset mid-operation: all counters and sticky bits clear next cycle. The downstream FIFO is reset by the same reset.

Optional Feature:
- Macro KCORE_START_CTRL_PERF_EN.
- Defined:
  - Adds output perf_iter_cnt[31:0]: increments on each ap_ready.
  - Adds output perf_stall_cnt[31:0]: increments each cycle ap_start=1 & ~all_go.
  - Both counters clear on reset and wrap modulo 2^32.
- Undefined: both ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then ap_start=1 with head_ready=2'b11, sfifo_full_n=1 → ap_ready and sfifo_write both high in the same cycle, inflight=1, ap_idle=0.
- head_ready[0]=1 at cycle 0, head_ready[1]=1 at cycle 3, FIFO not full → head_start=2'b10 for cycles 1-3, exactly one ap_ready at cycle 3, exactly one sfifo_write, at cycle 0.
- Heads always ready, sfifo_full_n=0 for 5 cycles then 1 → no ap_ready during the stall; write and ap_ready in the cycle full_n rises; perf_stall_cnt=5 when the feature is enabled.
- 4 iterations accepted, no tail_done; hold ap_start → head_start=0 and sfifo_write=0 while inflight=4. tail_done, then ap_continue → inflight=3 and the 5th iteration is accepted.
- 4 tail_done pulses with ap_continue=0 → done_cnt=4, tail_continue=0, ap_done=1. Assert ap_continue for 4 cycles → ap_done falls after the 4th, ap_idle=1.
- Same-cycle tail_done, ap_continue and all_go with inflight=2, done_cnt=1 → inflight=2, done_cnt=1 next cycle.
